// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Load/store initiator for the pipeline's data-memory port. Takes one request
// at a time from the MEM stage, checks it, and drives the DMEM byte/half/word
// port. Misaligned half/word accesses (when ALLOW_MISALIGNED=1) are split
// into sequential byte beats; loaded bytes are reassembled and sign- or
// zero-extended here. Faulty requests are answered with an error code and
// never reach DMEM.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both high. req_ready is high only in IDLE; resp_valid
// is high only in RESP and stays up, with data stable, until resp_ready.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_size,        store flag, size code (01 B, 10 H, 11 W),
//   req_signed               load sign-extension flag
//   req_addr, req_wdata      byte address, LSB-aligned store data
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     load result, error (00 ok, 01 misaligned,
//                            10 out of range, 11 illegal size)
//   dmem_addr, dmem_wdata    DMEM address / write data
//   dmem_mem_read            DMEM read code {sign, size}, 000 = idle
//   dmem_mem_write           DMEM write code (size), 00 = idle
//   dmem_rdata               DMEM combinational read data
//   dbg_state                current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int DMEM_SIZE        = 1024,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_err,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [2:0]            dmem_mem_read,
    output logic [1:0]            dmem_mem_write,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  we_q;
    logic [1:0]            size_q;
    logic                  sgn_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            beats_q;
    logic [1:0]            beat_q;
    logic [31:0]           asm_q;
    logic [31:0]           rdata_q;
    logic [1:0]            err_q;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic [2:0]  req_nbytes;
    logic [32:0] req_last;
    logic        req_oor;
    logic        req_misal;
    logic [1:0]  req_err;
    logic        accept;

    always_comb begin
        req_nbytes = 3'd1;
        case (req_size)
            2'b10:   req_nbytes = 3'd2;
            2'b11:   req_nbytes = 3'd4;
            default: req_nbytes = 3'd1;
        endcase
    end

    // 33-bit sum so an address that wraps past 2^32 still reads as out of range.
    assign req_last  = {1'b0, req_addr} + 33'(req_nbytes) - 33'd1;
    assign req_oor   = req_last > 33'(DMEM_SIZE - 1);
    assign req_misal = ((req_size == 2'b10) && req_addr[0]) ||
                       ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));

    always_comb begin
        req_err = 2'b00;
        if (req_size == 2'b00)                 req_err = 2'b11;
        else if (req_oor)                      req_err = 2'b10;
        else if (req_misal && !ALLOW_MISALIGNED) req_err = 2'b01;
    end

    assign accept = (state_q == S_IDLE) && req_valid;

    // ------------------------------------------------------------------
    // Beat bookkeeping and load reassembly
    // ------------------------------------------------------------------
    logic        split;
    logic        last_beat;
    logic [31:0] asm_next;
    logic [31:0] split_result;

    assign split     = (beats_q != 3'd1);
    assign last_beat = ({1'b0, beat_q} == (beats_q - 3'd1));

    // Assembly register with the current beat's byte already merged in, so
    // the final result can be formed in the last beat without an extra cycle.
    always_comb begin
        asm_next = asm_q;
        case (beat_q)
            2'd0:    asm_next[7:0]   = dmem_rdata[7:0];
            2'd1:    asm_next[15:8]  = dmem_rdata[7:0];
            2'd2:    asm_next[23:16] = dmem_rdata[7:0];
            default: asm_next[31:24] = dmem_rdata[7:0];
        endcase
    end

    assign split_result = (size_q == 2'b10) ?
                          {{16{sgn_q & asm_next[15]}}, asm_next[15:0]} :
                          asm_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = (req_err != 2'b00) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (last_beat) state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. DMEM strobes are gated by rst so nothing commits on
    // the reset edge.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready      = (state_q == S_IDLE);
        resp_valid     = (state_q == S_RESP);
        dmem_addr      = '0;
        dmem_wdata     = '0;
        dmem_mem_read  = 3'b000;
        dmem_mem_write = 2'b00;
        if ((state_q == S_ACCESS) && !rst) begin
            dmem_addr = addr_q + {30'd0, beat_q};
            if (split) begin
                if (we_q) begin
                    dmem_mem_write = 2'b01;
                    case (beat_q)
                        2'd0:    dmem_wdata = {24'd0, wdata_q[7:0]};
                        2'd1:    dmem_wdata = {24'd0, wdata_q[15:8]};
                        2'd2:    dmem_wdata = {24'd0, wdata_q[23:16]};
                        default: dmem_wdata = {24'd0, wdata_q[31:24]};
                    endcase
                end else begin
                    dmem_mem_read = 3'b001;
                end
            end else begin
                if (we_q) begin
                    dmem_mem_write = size_q;
                    dmem_wdata     = wdata_q;
                end else begin
                    dmem_mem_read = {sgn_q, size_q};
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            beats_q <= 3'd1;
            beat_q  <= 2'd0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        beats_q <= req_misal ? req_nbytes : 3'd1;
                        beat_q  <= 2'd0;
                        asm_q   <= '0;
                        rdata_q <= '0;
                        err_q   <= req_err;
                    end
                end
                S_ACCESS: begin
                    beat_q <= beat_q + 2'd1;
                    asm_q  <= asm_next;
                    if (last_beat && !we_q) begin
                        // Aligned loads are already extended by DMEM.
                        rdata_q <= split ? split_result : dmem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
